// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle adder, CHUNK_BITS per clock with a registered ripple carry
module chunked_adder #(
  parameter int NUM_BITS   = 16,
  parameter int CHUNK_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  localparam int NCHUNK = NUM_BITS / CHUNK_BITS;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t              state_q;
  logic [NUM_BITS-1:0] a_q;
  logic [NUM_BITS-1:0] b_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NUM_BITS-1:0] work_q;
  logic [NUM_BITS-1:0] work_d;
  logic [NUM_BITS-1:0] sum_q;
  logic                overflow_q;
  logic                busy_q;
  logic                done_q;
  logic [CHUNK_BITS:0] chunk_sum;

  // Operands shift down one chunk per cycle, so the active chunk is always the low slice.
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK_BITS-1:0]} + {1'b0, b_q[CHUNK_BITS-1:0]}
              + {{CHUNK_BITS{1'b0}}, carry_q};
  end

  // Each new chunk enters at the top; after NCHUNK cycles slice idx holds chunk idx.
  generate
    if (NCHUNK > 1) begin : g_multi
      always_comb work_d = {chunk_sum[CHUNK_BITS-1:0], work_q[NUM_BITS-1:CHUNK_BITS]};
    end else begin : g_single
      always_comb work_d = chunk_sum[CHUNK_BITS-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      work_q     <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in;
            idx_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          a_q     <= a_q >> CHUNK_BITS;
          b_q     <= b_q >> CHUNK_BITS;
          carry_q <= chunk_sum[CHUNK_BITS];
          work_q  <= work_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            sum_q      <= work_d;
            overflow_q <= chunk_sum[CHUNK_BITS];
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in;
            idx_q   <= '0;
            work_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - self-checking bench for chunked_adder (4-bit and 16-bit chunk instances)
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;

  logic        busy4, done4, ovf4;
  logic [15:0] sum4;
  logic        busy16, done16, ovf16;
  logic [15:0] sum16;

  int total = 0;
  int bad   = 0;
  logic [15:0] held;

  always #5 clk = ~clk;

  chunked_adder #(.NUM_BITS(16), .CHUNK_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(cin),
    .busy(busy4), .done(done4), .sum(sum4), .overflow(ovf4)
  );

  chunked_adder #(.NUM_BITS(16), .CHUNK_BITS(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(cin),
    .busy(busy16), .done(done16), .sum(sum16), .overflow(ovf16)
  );

  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  // Drives start for exactly one rising edge; returns at the falling edge after it.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({busy4, done4, ovf4} !== 3'b000 || sum4 !== 16'd0) begin bad++;
      $display("FAIL reset_initial: busy=%b done=%b sum=%0d ovf=%b want 0", busy4, done4, sum4, ovf4); end
    @(negedge clk) rst = 1'b0;
    issue(16'd1000, 16'd2000, 1'b0);
    repeat (6) @(negedge clk);
    total++; if (sum4 !== 16'd3000) begin bad++;
      $display("FAIL reset_preop: sum=%0d want 3000", sum4); end
    issue(16'd7, 16'd7, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if ({busy4, done4, ovf4} !== 3'b000 || sum4 !== 16'd0) begin bad++;
      $display("FAIL reset_async4: busy=%b done=%b sum=%0d ovf=%b want 0", busy4, done4, sum4, ovf4); end
    total++; if ({busy16, done16, ovf16} !== 3'b000 || sum16 !== 16'd0) begin bad++;
      $display("FAIL reset_async16: busy=%b done=%b sum=%0d ovf=%b want 0", busy16, done16, sum16, ovf16); end
    @(negedge clk) rst = 1'b0;
    held = 16'd0;
  endtask

  task automatic test_full_ripple();
    int n = 0;
    issue(16'hFFFF, 16'h0000, 1'b1);
    while (done4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL ripple_latency: edges=%0d want 4", n); end
    total++; if (sum4 !== 16'd0 || ovf4 !== 1'b1) begin bad++;
      $display("FAIL ripple_result: sum=%0d ovf=%b want 0/1", sum4, ovf4); end
    held = 16'd0;
  endtask

  task automatic test_basic();
    int n = 0;
    issue(16'd58000, 16'd10, 1'b0);
    while (done4 !== 1'b1 && n < 20) begin
      total++; if (busy4 !== 1'b1 || sum4 !== held) begin bad++;
        $display("FAIL basic_busy: cycle=%0d busy=%b sum=%0d want 1/%0d", n, busy4, sum4, held); end
      @(negedge clk); n++;
    end
    total++; if (n != 4) begin bad++; $display("FAIL basic_latency: edges=%0d want 4", n); end
    total++; if (busy4 !== 1'b0 || sum4 !== 16'd58010 || ovf4 !== 1'b0) begin bad++;
      $display("FAIL basic_result: busy=%b sum=%0d ovf=%b want 0/58010/0", busy4, sum4, ovf4); end
    @(negedge clk);
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL basic_pulse: done=%b want 0", done4); end
    held = 16'd58010;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int m = 0;
    issue(16'd43256, 16'd45217, 1'b0);
    while (done4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n != 4 || sum4 !== 16'd22937 || ovf4 !== 1'b1) begin bad++;
      $display("FAIL b2b_first: edges=%0d sum=%0d ovf=%b want 4/22937/1", n, sum4, ovf4); end
    a = 16'd24; b = 16'd13; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done4 !== 1'b1 && m < 20) begin
      total++; if (busy4 !== 1'b1 || sum4 !== 16'd22937) begin bad++;
        $display("FAIL b2b_busy: cycle=%0d busy=%b sum=%0d want 1/22937", m, busy4, sum4); end
      @(negedge clk); m++;
    end
    total++; if (m + 1 != 5) begin bad++; $display("FAIL b2b_gap: cycles=%0d want 5", m + 1); end
    total++; if (sum4 !== 16'd38 || ovf4 !== 1'b0) begin bad++;
      $display("FAIL b2b_second: sum=%0d ovf=%b want 38/0", sum4, ovf4); end
    held = 16'd38;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_operand_change();
    int dones = 0;
    issue(16'd15, 16'd45000, 1'b1);
    @(negedge clk);
    a = 16'd0; b = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done4 === 1'b1) dones++;
      if (dones == 0) begin
        total++; if (sum4 !== held) begin bad++;
          $display("FAIL opchg_hold: sum=%0d want %0d", sum4, held); end
      end
      @(negedge clk);
    end
    total++; if (dones != 1) begin bad++; $display("FAIL opchg_dones: count=%0d want 1", dones); end
    total++; if (sum4 !== 16'd45016 || ovf4 !== 1'b0) begin bad++;
      $display("FAIL opchg_result: sum=%0d ovf=%b want 45016/0", sum4, ovf4); end
    held = 16'd45016;
  endtask

  task automatic test_abort();
    int dones = 0;
    int n = 0;
    issue(16'd1234, 16'd4321, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if ({busy4, done4, ovf4} !== 3'b000 || sum4 !== 16'd0) begin bad++;
      $display("FAIL abort_reset: busy=%b done=%b sum=%0d ovf=%b want 0", busy4, done4, sum4, ovf4); end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done4 === 1'b1 || busy4 === 1'b1) dones++;
      @(negedge clk);
    end
    total++; if (dones != 0 || sum4 !== 16'd0) begin bad++;
      $display("FAIL abort_nodone: activity=%0d sum=%0d want 0/0", dones, sum4); end
    issue(16'd0, 16'd0, 1'b0);
    while (done4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++; if (n != 4 || sum4 !== 16'd0 || ovf4 !== 1'b0) begin bad++;
      $display("FAIL abort_zero_op: edges=%0d sum=%0d ovf=%b want 4/0/0", n, sum4, ovf4); end
    held = 16'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_chunk();
    int n = 0;
    issue(16'd40000, 16'd30000, 1'b1);
    while (done16 !== 1'b1 && n < 20) begin
      total++; if (busy16 !== 1'b1) begin bad++;
        $display("FAIL single_busy: busy=%b want 1", busy16); end
      @(negedge clk); n++;
    end
    total++; if (n != 1) begin bad++; $display("FAIL single_latency: edges=%0d want 1", n); end
    total++; if (sum16 !== 16'd4465 || ovf16 !== 1'b1) begin bad++;
      $display("FAIL single_result: sum=%0d ovf=%b want 4465/1", sum16, ovf16); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic        c;
    logic [16:0] r;
    int d4, d16;
    for (int i = 0; i < 24; i++) begin
      x = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      c = 1'($urandom);
      r = ref_add(x, y, c);
      issue(x, y, c);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      d4 = -1; d16 = -1;
      for (int k = 0; k < 8; k++) begin
        if (done4 === 1'b1 && d4 < 0) d4 = k;
        if (done16 === 1'b1 && d16 < 0) d16 = k;
        @(negedge clk);
      end
      total++; if (d4 != 4 || sum4 !== r[15:0] || ovf4 !== r[16]) begin bad++;
        $display("FAIL rand4 #%0d: %0d+%0d+%0d got edges=%0d sum=%0d ovf=%b want 4/%0d/%b",
                 i, x, y, c, d4, sum4, ovf4, r[15:0], r[16]); end
      total++; if (d16 != 1 || sum16 !== r[15:0] || ovf16 !== r[16]) begin bad++;
        $display("FAIL rand16 #%0d: %0d+%0d+%0d got edges=%0d sum=%0d ovf=%b want 1/%0d/%b",
                 i, x, y, c, d16, sum16, ovf16, r[15:0], r[16]); end
    end
  endtask

  initial begin
    held = 16'd0;
    test_reset();
    test_full_ripple();
    test_basic();
    test_back_to_back();
    test_operand_change();
    test_abort();
    test_single_chunk();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
